// File: rtl/adder10_carry_seq.sv
// Word-serial adder: adds two multi-word operands one W-bit word per cycle,
// least-significant word first, chaining the carry between words.
module adder10_carry_seq #(
  parameter int W    = 10,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_a,
  input  logic [W-1:0]    in_b,
  input  logic            in_cin,
  input  logic            in_first,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_sum,
  output logic            out_last,
  output logic            out_cout,
  output logic            busy,
  output logic [CNTW-1:0] word_cnt,
  output logic            proto_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_p0;
  logic              carry_p0;
  logic [CNTW-1:0]   cnt_p0;
  logic              err_p0;
  logic              vld_p1;
  logic [W-1:0]      sum_p1;
  logic              last_p1;
  logic              cout_p1;

  logic              accept;
  logic              eff_first;
  logic              err_now;
  logic              cy;
  logic [W:0]        add_p0;

  function automatic logic [W:0] add_word(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic         ci);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == {CNTW{1'b1}}) ? c : c + 1'b1;
  endfunction

  assign in_ready = ~vld_p1 | out_ready;

  // A non-first word arriving while idle is treated as the start of an operation.
  always_comb begin
    accept    = in_valid & in_ready;
    eff_first = in_first | (state_p0 == IDLE);
    err_now   = (in_first & (state_p0 == RUN)) | (~in_first & (state_p0 == IDLE));
    cy        = eff_first ? in_cin : carry_p0;
    add_p0    = add_word(in_a, in_b, cy);
  end

  // p0 -> p1: register sum word, carry chain, operation state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      carry_p0 <= 1'b0;
      cnt_p0   <= '0;
      err_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      sum_p1   <= '0;
      last_p1  <= 1'b0;
      cout_p1  <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      sum_p1   <= add_p0[W-1:0];
      last_p1  <= in_last;
      cout_p1  <= add_p0[W] & in_last;
      carry_p0 <= add_p0[W];
      cnt_p0   <= eff_first ? {{(CNTW-1){1'b0}}, 1'b1} : sat_inc(cnt_p0);
      state_p0 <= in_last ? IDLE : RUN;
      if (err_now)
        err_p0 <= 1'b1;
    end else if (vld_p1 && out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_sum   = sum_p1;
  assign out_last  = last_p1;
  assign out_cout  = cout_p1;
  assign busy      = (state_p0 == RUN);
  assign word_cnt  = cnt_p0;
  assign proto_err = err_p0;

endmodule

// File: tb/tb_adder10_carry_seq.sv
// Bench for adder10_carry_seq: directed vector table, hand-written corner
// sequences, and random multi-word operations checked against wide-integer sums.
module tb_adder10_carry_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_a, in_b;
  logic       in_cin, in_first, in_last;
  logic       out_valid, out_ready;
  logic [9:0] out_sum;
  logic       out_last, out_cout, busy, proto_err;
  logic [7:0] word_cnt;

  int tests = 0;
  int fails = 0;

  adder10_carry_seq #(.W(10), .CNTW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_first(in_first),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last), .out_cout(out_cout),
    .busy(busy), .word_cnt(word_cnt), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] a, b;
    logic       cin, first, last;
    logic [9:0] sum;
    logic       olast, cout, busy;
    logic [7:0] cnt;
    logic       err;
  } vec_t;

  typedef struct {
    logic [9:0] a, b;
    logic       cin, first, last;
  } word_t;

  typedef struct {
    logic [9:0] sum;
    logic       last, cout;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] a, input logic [9:0] b,
                       input logic ci, input logic f, input logic l);
    in_valid = v; in_a = a; in_b = b; in_cin = ci; in_first = f; in_last = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t  tbl[8];
  word_t in_q[$];
  exp_t  exp_q[$];

  initial begin
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    //        a      b      cin f  l  sum    olast cout busy cnt err
    tbl[0] = '{10'h3FF, 10'h001, 0, 1, 1, 10'h000, 1, 1, 0, 8'd1, 0};
    tbl[1] = '{10'h3FF, 10'h001, 1, 1, 0, 10'h001, 0, 0, 1, 8'd1, 0};
    tbl[2] = '{10'h3FF, 10'h000, 0, 0, 0, 10'h000, 0, 0, 1, 8'd2, 0};
    tbl[3] = '{10'h000, 10'h000, 0, 0, 1, 10'h001, 1, 0, 0, 8'd3, 0};
    tbl[4] = '{10'h100, 10'h0FF, 1, 0, 1, 10'h200, 1, 0, 0, 8'd1, 1};
    tbl[5] = '{10'h3FF, 10'h3FF, 0, 1, 0, 10'h3FE, 0, 0, 1, 8'd1, 1};
    tbl[6] = '{10'h001, 10'h002, 0, 1, 0, 10'h003, 0, 0, 1, 8'd1, 1};
    tbl[7] = '{10'h3FF, 10'h000, 1, 0, 1, 10'h3FF, 1, 0, 0, 8'd2, 1};

    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum",   out_sum,   0);
    chk("rst_out_last",  out_last,  0);
    chk("rst_out_cout",  out_cout,  0);
    chk("rst_busy",      busy,      0);
    chk("rst_word_cnt",  word_cnt,  0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_in_ready",  in_ready,  1);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].first, tbl[i].last);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), out_valid, 1);
      chk($sformatf("vec%0d_sum",   i), out_sum,   tbl[i].sum);
      chk($sformatf("vec%0d_last",  i), out_last,  tbl[i].olast);
      chk($sformatf("vec%0d_cout",  i), out_cout,  tbl[i].cout);
      chk($sformatf("vec%0d_busy",  i), busy,      tbl[i].busy);
      chk($sformatf("vec%0d_cnt",   i), word_cnt,  tbl[i].cnt);
      chk($sformatf("vec%0d_err",   i), proto_err, tbl[i].err);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drain_valid", out_valid, 0);

    // Backpressure: second word must wait, first word must hold.
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, 10'h001, 10'h002, 1'b0, 1'b1, 1'b1);
    #1 chk("bp_ready0", in_ready, 1);
    @(negedge clk);
    drive(1'b1, 10'h005, 10'h006, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_stall_ready%0d", i), in_ready, 0);
      chk($sformatf("bp_stall_sum%0d", i), out_sum, 10'h003);
      chk($sformatf("bp_stall_valid%0d", i), out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("bp_second_valid", out_valid, 1);
    chk("bp_second_sum", out_sum, 10'h00B);
    @(negedge clk);
    chk("bp_empty", out_valid, 0);

    // Reset in the middle of an operation (which also raised proto_err).
    do_reset();
    drive(1'b1, 10'h011, 10'h022, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_err_set", proto_err, 1);
    drive(1'b1, 10'h033, 10'h044, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy",  busy,      0);
    chk("mid_rst_cnt",   word_cnt,  0);
    chk("mid_rst_err",   proto_err, 0);
    drive(1'b1, 10'h155, 10'h2AA, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("post_rst_sum",  out_sum,  10'h000);
    chk("post_rst_cout", out_cout, 1);
    chk("post_rst_last", out_last, 1);

    // 300-word all-zero operation: counter saturates at 255.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, '0, '0, 1'b0, i == 0, i == 299);
      @(negedge clk);
      if (i == 199) chk("sat_cnt200", word_cnt, 200);
      if (i == 254) chk("sat_cnt255", word_cnt, 255);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("sat_cnt_final", word_cnt, 255);
    chk("sat_last",      out_last, 1);
    chk("sat_cout",      out_cout, 0);
    chk("sat_sum",       out_sum,  0);
    chk("sat_busy",      busy,     0);

    // Random multi-word operations with random backpressure and idle gaps.
    do_reset();
    for (int op = 0; op < 150; op++) begin
      int         n;
      logic [63:0] ta, tb, tot;
      logic       ci;
      n  = $urandom_range(1, 5);
      ci = 1'($urandom_range(0, 1));
      ta = '0; tb = '0;
      for (int w = 0; w < n; w++) begin
        word_t wd;
        wd.a = 10'($urandom); wd.b = 10'($urandom);
        wd.cin = ci; wd.first = (w == 0); wd.last = (w == n - 1);
        if (w != 0) wd.cin = 1'($urandom_range(0, 1));
        ta = ta | (64'(wd.a) << (10 * w));
        tb = tb | (64'(wd.b) << (10 * w));
        in_q.push_back(wd);
      end
      tot = ta + tb + 64'(ci);
      for (int w = 0; w < n; w++) begin
        exp_t e;
        e.sum  = 10'(tot >> (10 * w));
        e.last = (w == n - 1);
        e.cout = (w == n - 1) ? tot[10 * n] : 1'b0;
        exp_q.push_back(e);
      end
    end

    begin
      bit hold = 0;
      int cyc  = 0;
      while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < 5000) begin
        cyc++;
        out_ready = ($urandom_range(0, 3) != 0);
        if (in_q.size() != 0 && (hold || $urandom_range(0, 3) != 0))
          drive(1'b1, in_q[0].a, in_q[0].b, in_q[0].cin, in_q[0].first, in_q[0].last);
        else
          drive(1'b0, 10'($urandom), 10'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        #1;
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("rnd_extra_word", 1, 0);
          end else begin
            chk("rnd_word", {out_sum, out_last, out_cout},
                {exp_q[0].sum, exp_q[0].last, exp_q[0].cout});
            void'(exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) begin
          void'(in_q.pop_front());
          hold = 0;
        end else begin
          hold = in_valid;
        end
        @(negedge clk);
      end
      chk("rnd_all_drained", exp_q.size() + in_q.size(), 0);
      chk("rnd_no_proto_err", proto_err, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/adder10_carry_seq.md
ADDER10_CARRY_SEQ -- requirements
Module: adder10_carry_seq

Interface
REQ-001 Parameter: W, 10, operand/sum word width per cycle.
REQ-002 Parameter: CNTW, 8, width of the word counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  operand word pair presented.
REQ-006 in_ready  output  1  block accepts the word pair this cycle.
REQ-007 in_a  input  W  operand A word, least-significant word first.
REQ-008 in_b  input  W  operand B word.
REQ-009 in_cin  input  1  carry-in; sampled only on a word with in_first=1.
REQ-010 in_first  input  1  first (least-significant) word of an operation.
REQ-011 in_last  input  1  last (most-significant) word of an operation; may coincide with in_first.
REQ-012 out_valid  output  1  sum word available.
REQ-013 out_ready  input  1  downstream accepts the sum word.
REQ-014 out_sum  output  W  sum word.
REQ-015 out_last  output  1  sum word is the final word of the operation.
REQ-016 out_cout  output  1  final carry-out; meaningful only when out_last=1, else 0.
REQ-017 busy  output  1  an operation is open (first accepted, last not yet accepted).
REQ-018 word_cnt  output  CNTW  words accepted in the current or most recent operation.
REQ-019 proto_err  output  1  sticky protocol-error flag.

Function
REQ-020 Accept = in_valid & in_ready; in_ready SHALL equal (~out_valid | out_ready), i.e. full throughput with a single output register.
REQ-021 Per accepted word: {c, s} = in_a + in_b + cy, with cy = in_cin if in_first else the carry register; arithmetic is W+1 bits, no truncation of c.
REQ-022 On accept, out_sum <= s, out_last <= in_last, out_cout <= c & in_last, out_valid <= 1 on the next edge (latency 1 cycle).
REQ-023 Carry register SHALL load c on every accept; it is ignored on the next in_first word.
REQ-024 If out_valid & out_ready and no accept, out_valid <= 0; outputs hold while out_valid & ~out_ready.
REQ-025 FSM states IDLE, RUN; IDLE->RUN on accepted in_first & ~in_last; RUN->IDLE on accepted in_last; IDLE stays IDLE on accepted in_first & in_last; busy = (state==RUN).
REQ-026 word_cnt <= 1 on accepted in_first; increments on other accepts; saturates at 2^CNTW-1.
REQ-027 Accepted word with in_first=0 in IDLE: proto_err <= 1, word treated as in_first with cy = in_cin, FSM follows REQ-025 as if first.
REQ-028 Accepted in_first=1 in RUN: proto_err <= 1, open operation abandoned, new operation started per REQ-021/REQ-025 (no flush of already-registered output).
REQ-029 proto_err clears only on rst.
REQ-030 in_a, in_b, in_cin, in_first, in_last SHALL be ignored when no accept occurs; no state changes without accept except REQ-024.

Reset
REQ-031 While rst=1 at an edge: state<=IDLE, out_valid<=0, out_sum<=0, out_last<=0, out_cout<=0, carry<=0, word_cnt<=0, proto_err<=0; in_ready=1 the following cycle.
REQ-032 rst mid-operation SHALL discard the open operation and any pending output word; rst has priority over accept in the same cycle.

Verification
REQ-033 Single word: first=last=1, a=0x3FF, b=0x001, cin=0, out_ready=1 -> next cycle out_valid=1, sum=0x000, last=1, cout=1, busy=0, word_cnt=1.
REQ-034 Three-word 30-bit add: words (0x3FF,0x001,cin=1),(0x3FF,0x000),(0x000,0x000,last) -> sums 0x001, 0x000, 0x001; cout=0; word_cnt=3; carry chained each cycle.
REQ-035 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first accept, out_sum stable, no word lost or duplicated after out_ready=1.
REQ-036 Protocol errors: first word with in_first=0 in IDLE -> proto_err=1, sum uses in_cin; in_first=1 while busy -> proto_err=1, word_cnt=1, new carry from in_cin.
REQ-037 rst asserted during word 2 of 3 -> out_valid=0, busy=0, word_cnt=0, proto_err=0 next cycle; subsequent single-word op 0x155+0x2AA+1 -> sum 0x000, cout=1.
REQ-038 Saturation: 300-word operation, all zeros -> word_cnt holds 255, final out_last=1, cout=0.
